// File: rtl/sign_code_fifo.sv
// sign_code_fifo
// Takes matched gesture codes from the matcher stage and queues them for the
// text/display stage.
//   Stage 1 registers the hit strobe and code, dropping idle codes.
//   Stage 2 discards repeats of the last accepted code inside a hold window,
//   then pushes the code into a first-word-fall-through FIFO.
// Ports:
//   CLK        clock, all logic on the rising edge
//   RST        synchronous active-low reset
//   CLR        active-low hit strobe; DATA is valid when CLR==0
//   DATA       6-bit code from the matcher
//   OUT_READY  consumer takes OUT_DATA this cycle
//   CLR_OVF    clears OVF and DROP_CNT; a drop in the same cycle wins
//   OUT_DATA   head of FIFO, IDLE_CODE when empty
//   OUT_VALID  FIFO non-empty
//   LEVEL      occupancy, 0..DEPTH
//   OVF        sticky flag: a code was lost to a full FIFO
//   DROP_CNT   saturating count of codes lost to a full FIFO
module sign_code_fifo #(
    parameter int          DEPTH       = 8,
    parameter int          REPEAT_HOLD = 16,
    parameter logic [5:0]  IDLE_CODE   = 6'd63
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CLR,
    input  logic [5:0]               DATA,
    input  logic                     OUT_READY,
    input  logic                     CLR_OVF,
    output logic [5:0]               OUT_DATA,
    output logic                     OUT_VALID,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     OVF,
    output logic [7:0]               DROP_CNT
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int HW = (REPEAT_HOLD < 1) ? 1 : $clog2(REPEAT_HOLD + 1);
    localparam logic [LW-1:0] FULL_L = LW'(DEPTH);
    localparam logic [HW-1:0] HOLD_L = HW'(REPEAT_HOLD);

    // capture stage
    logic          cap_vld_q, cap_vld_d;
    logic [5:0]    cap_code_q;

    // repeat filter
    logic [5:0]    last_q, last_d;
    logic [HW-1:0] hold_q, hold_d;

    // FIFO
    logic [5:0]    mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [LW-1:0] level_q, level_d;

    // overflow bookkeeping
    logic          ovf_q, ovf_d;
    logic [7:0]    drop_q, drop_d;

    logic dup, cand, pop, push, drop;

    always_comb begin
        cap_vld_d = !CLR && (DATA != IDLE_CODE);

        // hold_q != 0 only while a window is open; REPEAT_HOLD==0 never opens one
        dup  = cap_vld_q && (cap_code_q == last_q) && (hold_q != '0);
        cand = cap_vld_q && !dup;
        pop  = (level_q != '0) && OUT_READY;
        // a pop frees the slot this same edge, so a full FIFO can still accept
        push = cand && ((level_q < FULL_L) || pop);
        drop = cand && !push;

        last_d  = last_q;
        hold_d  = hold_q;
        if (push) begin
            last_d = cap_code_q;
            hold_d = HOLD_L;
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end

        rd_d    = pop  ? rd_q + 1'b1 : rd_q;
        wr_d    = push ? wr_q + 1'b1 : wr_q;
        level_d = level_q;
        if (push && !pop)      level_d = level_q + 1'b1;
        else if (pop && !push) level_d = level_q - 1'b1;

        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (drop) begin
            ovf_d  = 1'b1;
            drop_d = CLR_OVF ? 8'd1 : ((drop_q == 8'hFF) ? drop_q : drop_q + 8'd1);
        end else if (CLR_OVF) begin
            ovf_d  = 1'b0;
            drop_d = 8'd0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cap_vld_q  <= 1'b0;
            cap_code_q <= IDLE_CODE;
            last_q     <= IDLE_CODE;
            hold_q     <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            drop_q     <= 8'd0;
        end else begin
            cap_vld_q  <= cap_vld_d;
            cap_code_q <= DATA;
            last_q     <= last_d;
            hold_q     <= hold_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
        end
    end

    // storage needs no reset: it is only read where level_q marks it occupied
    always_ff @(posedge CLK) begin
        if (RST && push) mem_q[wr_q] <= cap_code_q;
    end

    assign OUT_VALID = (level_q != '0);
    assign OUT_DATA  = OUT_VALID ? mem_q[rd_q] : IDLE_CODE;
    assign LEVEL     = level_q;
    assign OVF       = ovf_q;
    assign DROP_CNT  = drop_q;

endmodule
